spi_xfer_scheduler: RTL and testbench
=====================================

Name: spi_xfer_scheduler

Overview:
Round-robin arbiter and sequencer that shares one SPI master among NUM_REQ requesters. It grants one requester at a time and feeds that requester's words to the master one at a time. Each returned MISO word is routed back tagged with the requester ID. Between bursts it inserts an idle gap so the master returns to IDLE and deasserts SSbar.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_LENGTH, 8, SPI word width; matches master word width
LEN_W, 4, width of per-requester burst-length field
GAP_CYCLES, 2, idle clk cycles between bursts (>=1)
TIMEOUT, 1024, watchdog limit in clk cycles (only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester burst request, level
req_len  in  NUM_REQ*LEN_W  per-requester word count; slice i = [i*LEN_W +: LEN_W]
req_wdata  in  NUM_REQ*WORD_LENGTH  per-requester next TX word
gnt  out  NUM_REQ  one-hot grant, held for the whole burst
wdata_ack  out  NUM_REQ  1-cycle pulse: current req_wdata slice consumed; requester advances to next word
rdata  out  WORD_LENGTH  received word
rdata_valid  out  1  1-cycle pulse, rdata/rdata_id valid
rdata_id  out  $clog2(NUM_REQ)  owner of rdata
burst_done  out  1  1-cycle pulse at end of burst
busy  out  1  high in any state except IDLE
m_ready  in  1  master ready (SPI_status_RDY_BSYbar)
m_start  out  1  1-cycle word-launch pulse to master
m_wdata  out  WORD_LENGTH  word to master, stable from m_start until m_done
m_rdata  in  WORD_LENGTH  master RX word
m_done  in  1  master word-complete pulse; m_rdata valid
err  out  1  watchdog abort pulse; tied 0 without the optional feature

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0. All outputs 0: gnt, wdata_ack, rdata, rdata_valid, rdata_id, burst_done, busy, m_start, m_wdata, err.
- All outputs are registered.
- States: IDLE, LOAD, WAIT, GAP.
- Eligibility: requester i is eligible when req[i]=1 and req_len slice i != 0. Length-0 requesters are never granted.
- IDLE:
  - Choose the first eligible index searching from rr_ptr upward, with wrap.
  - Next cycle: gnt[i]=1, latch id=i and cnt=req_len[i], set rr_ptr=(i+1) mod NUM_REQ, go to LOAD.
  - No eligible requester: stay in IDLE.
- LOAD:
  - When m_ready=1: next cycle m_start=1, m_wdata=req_wdata[id], wdata_ack[id]=1, go to WAIT.
  - m_ready=0: hold in LOAD.
- WAIT:
  - On m_done: next cycle rdata=m_rdata, rdata_id=id, rdata_valid=1, cnt=cnt-1.
  - If cnt was 1: burst_done=1, gnt=0, go to GAP. Otherwise go to LOAD.
  - m_done outside WAIT is ignored.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Minimum latency: req sampled at edge N, gnt at N+1, m_start at N+2 (if m_ready=1).
- Per-word throughput is bounded by the master.
- req deassert mid-burst: ignored; the burst completes all cnt words. req_len changes after grant are ignored.
- A requester still requesting after its burst competes again only after GAP; rr_ptr prevents back-to-back wins while others are eligible.
- Single eligible requester: re-granted after each GAP.
- cnt is LEN_W bits; req_len all-ones gives 2^LEN_W-1 words, no wrap.

Optional Feature:
SPI_XFER_SCHED_TIMEOUT_EN
- Defined: a watchdog counts cycles in WAIT and clears on m_done. On reaching TIMEOUT: err pulses 1 cycle, burst_done pulses, gnt clears, remaining words are dropped (no rdata_valid), state goes to GAP. rr_ptr advances normally.
- Undefined: no counter; err is constant 0; WAIT waits indefinitely.

Test Plan:
- Single burst: req[2]=1, len=3, wdata 0xA1/0xA2/0xA3, master loops back MOSI->MISO -> 3 m_start pulses with m_wdata A1,A2,A3; 3 rdata_valid with rdata_id=2 and rdata A1,A2,A3; 1 burst_done; gnt=4'b0100 throughout; gnt=0 afterwards for exactly GAP_CYCLES cycles before IDLE.
- Round robin: req=4'b1111, all len=1, from reset -> grant order 0,1,2,3,0; rr_ptr wraps.
- Length-0 skip: req=4'b0011, len0=0, len1=2 -> only requester 1 is granted; 2 words; requester 0 never granted.
- Backpressure: m_ready=0 for 10 cycles after gnt -> m_start held off; fires 1 cycle after m_ready rises; m_done while in LOAD produces no rdata_valid.
- Reset mid-burst: rst_n low during WAIT of word 2 of 4 -> all outputs 0 immediately; after release, rr_ptr=0 and requester 0 is granted first.
- Timeout (macro defined, TIMEOUT=16): no m_done after m_start -> err and burst_done pulse on the same cycle, 16 cycles after entering WAIT; then gnt=0; next requester is granted after GAP.

Source files
------------

// File: rtl/spi_xfer_scheduler.sv
// spi_xfer_scheduler: round-robin arbiter that shares one SPI master among NUM_REQ requesters.
// It feeds the granted requester's words to the master one at a time and routes MISO words back
// tagged with the requester id. An idle gap between bursts lets the master return to IDLE.
// Optional WAIT watchdog: define SPI_XFER_SCHED_TIMEOUT_EN (limit set by TIMEOUT).
module spi_xfer_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int LEN_W       = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LEN_W-1:0]       req_len,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             wdata_ack,
    output logic [WORD_LENGTH-1:0]         rdata,
    output logic                           rdata_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rdata_id,
    output logic                           burst_done,
    output logic                           busy,
    input  logic                           m_ready,
    output logic                           m_start,
    output logic [WORD_LENGTH-1:0]         m_wdata,
    input  logic [WORD_LENGTH-1:0]         m_rdata,
    input  logic                           m_done,
    output logic                           err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int GW  = $clog2(GAP_CYCLES + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;
    state_t state, state_n;

    logic [IDW-1:0]         rr_ptr, id, pick, id_d, rid_d;
    logic [LEN_W-1:0]       cnt;
    logic [GW-1:0]          gap_cnt;
    logic [NUM_REQ-1:0]     elig, gnt_d, ack_d;
    logic [WORD_LENGTH-1:0] wdata_d, rdata_d;
    logic                   found, last, gap_last, wd_hit;
    logic                   start_d, rvalid_d, done_d, busy_d;

    assign last     = cnt == LEN_W'(1);
    assign gap_last = gap_cnt == GW'(GAP_CYCLES - 1);

    // a requester is eligible only with a pending request and a non-zero word count
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end

    // first eligible index searching upward from rr_ptr with wrap
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next-state logic; a late m_done wins over a simultaneous watchdog expiry
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? LOAD : IDLE;
            LOAD:    state_n = m_ready ? WAIT : LOAD;
            WAIT:    state_n = m_done ? (last ? GAP : LOAD) : (wd_hit ? GAP : WAIT);
            GAP:     state_n = gap_last ? IDLE : GAP;
            default: state_n = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        id_d     = (state == IDLE) ? pick : id;
        gnt_d    = (state_n == LOAD || state_n == WAIT) ? ONE << id_d : '0;
        start_d  = (state == LOAD) && m_ready;
        ack_d    = start_d ? ONE << id : '0;
        wdata_d  = start_d ? req_wdata[int'(id)*WORD_LENGTH +: WORD_LENGTH] : m_wdata;
        rvalid_d = (state == WAIT) && m_done;
        rdata_d  = rvalid_d ? m_rdata : rdata;
        rid_d    = rvalid_d ? id : rdata_id;
        done_d   = (state == WAIT) && (state_n == GAP);
        busy_d   = state_n != IDLE;
    end

    // output registers plus burst bookkeeping (owner, words left, pointer, gap timer)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            wdata_ack   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_id    <= '0;
            burst_done  <= 1'b0;
            busy        <= 1'b0;
            m_start     <= 1'b0;
            m_wdata     <= '0;
            rr_ptr      <= '0;
            id          <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
        end else begin
            gnt         <= gnt_d;
            wdata_ack   <= ack_d;
            rdata       <= rdata_d;
            rdata_valid <= rvalid_d;
            rdata_id    <= rid_d;
            burst_done  <= done_d;
            busy        <= busy_d;
            m_start     <= start_d;
            m_wdata     <= wdata_d;
            gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (state == IDLE && found) begin
                id     <= pick;
                cnt    <= req_len[int'(pick)*LEN_W +: LEN_W];
                rr_ptr <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
            end
            if (rvalid_d) cnt <= cnt - 1'b1;
        end
    end

`ifdef SPI_XFER_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;

    assign wd_hit = (state == WAIT) && !m_done && (wd == WDW'(TIMEOUT - 1));

    // watchdog: consecutive WAIT cycles without m_done; err pulses on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= (state == WAIT && !m_done) ? wd + 1'b1 : '0;
            err <= wd_hit;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// tb_spi_xfer_scheduler: directed self-checking bench for spi_xfer_scheduler (4 requesters, 8-bit words).
module tb_spi_xfer_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt, wdata_ack;
    logic [7:0]  rdata, m_wdata;
    logic        rdata_valid, burst_done, busy, m_start, err;
    logic [1:0]  rdata_id;
    logic        m_ready = 1'b1;
    logic [7:0]  m_rdata = '0;
    logic        m_done = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] base [4];
    logic [7:0] ptr [4];
    logic [7:0] q_start [$];
    logic [9:0] q_rv [$];
    logic [3:0] q_gnt [$];
    int         n_done = 0;
    logic [3:0] prev_gnt = '0;
    logic       auto_m = 1'b0;

    spi_xfer_scheduler #(.NUM_REQ(4), .WORD_LENGTH(8), .LEN_W(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_wdata(req_wdata),
        .gnt(gnt), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
        .rdata_id(rdata_id), .burst_done(burst_done), .busy(busy), .m_ready(m_ready),
        .m_start(m_start), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 400 && !burst_done; t++) tick();
        chk(tag, {31'd0, burst_done}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 100 && busy; t++) tick();
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_logs();
        q_start.delete();
        q_rv.delete();
        q_gnt.delete();
        n_done = 0;
        for (int i = 0; i < 4; i++) ptr[i] = '0;
    endtask

    // requester model: present base+index, advance on wdata_ack
    initial begin
        for (int i = 0; i < 4; i++) begin
            base[i] = '0;
            ptr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (wdata_ack[i]) ptr[i] = ptr[i] + 8'd1;
                req_wdata[i*8 +: 8] = base[i] + ptr[i];
            end
        end
    end

    // loopback master: echoes m_wdata on m_rdata three cycles after m_start
    initial forever begin
        @(negedge clk);
        if (auto_m && m_start) begin
            repeat (3) @(negedge clk);
            m_rdata = m_wdata;
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
        end
    end

    // event recorder
    initial forever begin
        @(negedge clk);
        if (m_start) q_start.push_back(m_wdata);
        if (rdata_valid) q_rv.push_back({rdata_id, rdata});
        if (burst_done) n_done++;
        if (gnt != 4'd0 && prev_gnt == 4'd0) q_gnt.push_back(gnt);
        prev_gnt = gnt;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        // reset values
        repeat (3) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", wdata_ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_rid", rdata_id, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_mwdata", m_wdata, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // single burst, requester 2, three words
        clear_logs();
        auto_m = 1'b1;
        base[2] = 8'hA1;
        req_len = 16'h0300;
        req = 4'b0100;
        tick();
        chk("sb_gnt", gnt, 4'b0100);
        chk("sb_nostart", m_start, 0);
        chk("sb_busy", busy, 1);
        tick();
        chk("sb_start", m_start, 1);
        chk("sb_mwdata", m_wdata, 8'hA1);
        chk("sb_ack", wdata_ack, 4'b0100);
        wait_done("sb_done");
        req = 4'b0000;
        chk("sb_gnt_off", gnt, 0);
        chk("sb_gap0_busy", busy, 1);
        tick();
        chk("sb_gap1_busy", busy, 1);
        chk("sb_gap1_gnt", gnt, 0);
        tick();
        chk("sb_idle_busy", busy, 0);
        tick();
        chk("sb_nstart", q_start.size(), 3);
        chk("sb_start1", q_start[1], 8'hA2);
        chk("sb_start2", q_start[2], 8'hA3);
        chk("sb_nrv", q_rv.size(), 3);
        chk("sb_rv0", q_rv[0], {2'd2, 8'hA1});
        chk("sb_rv1", q_rv[1], {2'd2, 8'hA2});
        chk("sb_rv2", q_rv[2], {2'd2, 8'hA3});
        chk("sb_ndone", n_done, 1);

        // round robin from reset, all length 1
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_logs();
        req_len = 16'h1111;
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            wait_done("rr_done");
            if (b == 4) req = 4'b0000;
            tick();
        end
        wait_idle("rr_idle");
        tick();
        chk("rr_ngnt", q_gnt.size(), 5);
        chk("rr_g0", q_gnt[0], 4'b0001);
        chk("rr_g1", q_gnt[1], 4'b0010);
        chk("rr_g2", q_gnt[2], 4'b0100);
        chk("rr_g3", q_gnt[3], 4'b1000);
        chk("rr_g4", q_gnt[4], 4'b0001);

        // length-0 requester skipped
        clear_logs();
        base[1] = 8'h51;
        req_len = 16'h0020;
        req = 4'b0011;
        wait_done("l0_done");
        req = 4'b0000;
        wait_idle("l0_idle");
        repeat (3) tick();
        chk("l0_ngnt", q_gnt.size(), 1);
        chk("l0_gnt", q_gnt[0], 4'b0010);
        chk("l0_nrv", q_rv.size(), 2);
        chk("l0_rv0", q_rv[0], {2'd1, 8'h51});
        chk("l0_rv1", q_rv[1], {2'd1, 8'h52});

        // backpressure and stray m_done in LOAD
        clear_logs();
        auto_m = 1'b0;
        m_ready = 1'b0;
        base[3] = 8'hD0;
        req_len = 16'h1000;
        req = 4'b1000;
        tick();
        chk("bp_gnt", gnt, 4'b1000);
        for (int t = 0; t < 10; t++) begin
            m_done = (t == 4);
            tick();
        end
        m_done = 1'b0;
        chk("bp_held_nstart", q_start.size(), 0);
        chk("bp_held_nrv", q_rv.size(), 0);
        chk("bp_held_gnt", gnt, 4'b1000);
        m_ready = 1'b1;
        tick();
        chk("bp_start", m_start, 1);
        chk("bp_mwdata", m_wdata, 8'hD0);
        chk("bp_ack", wdata_ack, 4'b1000);
        m_rdata = 8'h3C;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        req = 4'b0000;
        chk("bp_rvalid", rdata_valid, 1);
        chk("bp_rdata", rdata, 8'h3C);
        chk("bp_rid", rdata_id, 3);
        chk("bp_done", burst_done, 1);
        chk("bp_gnt_off", gnt, 0);
        wait_idle("bp_idle");

        // reset during WAIT of word 2 of 4
        clear_logs();
        auto_m = 1'b1;
        base[2] = 8'h20;
        req_len = 16'h0400;
        req = 4'b0100;
        for (int t = 0; t < 100 && q_start.size() < 2; t++) tick();
        chk("mr_two_starts", q_start.size(), 2);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_gnt", gnt, 0);
        chk("mr_busy", busy, 0);
        chk("mr_mwdata", m_wdata, 0);
        chk("mr_rdata", rdata, 0);
        chk("mr_rid", rdata_id, 0);
        chk("mr_rvalid", rdata_valid, 0);
        repeat (6) tick();
        req_len = 16'h1111;
        req = 4'b1111;
        rst_n = 1'b1;
        tick();
        chk("mr_first_gnt", gnt, 4'b0001);
        req = 4'b0000;
        wait_done("mr_done");
        wait_idle("mr_idle");

        // maximum length burst (15 words)
        tick();
        clear_logs();
        base[0] = 8'h10;
        req_len = 16'h000F;
        req = 4'b0001;
        wait_done("max_done");
        req = 4'b0000;
        tick();
        chk("max_nstart", q_start.size(), 15);
        chk("max_nrv", q_rv.size(), 15);
        chk("max_rv14", q_rv[14], {2'd0, 8'h1E});
        chk("max_ndone", n_done, 1);
        wait_idle("max_idle");

`ifdef SPI_XFER_SCHED_TIMEOUT_EN
        // watchdog: no m_done after m_start
        tick();
        clear_logs();
        auto_m = 1'b0;
        base[1] = 8'h60;
        base[2] = 8'h70;
        req_len = 16'h0120;
        req = 4'b0110;
        tick();
        chk("to_gnt", gnt, 4'b0010);
        tick();
        chk("to_start", m_start, 1);
        chk("to_mwdata", m_wdata, 8'h60);
        begin
            logic seen;
            seen = 1'b0;
            for (int t = 0; t < 15; t++) begin
                tick();
                seen = seen | err | burst_done;
            end
            chk("to_early", seen, 0);
        end
        tick();
        chk("to_err", err, 1);
        chk("to_done", burst_done, 1);
        chk("to_gnt_off", gnt, 0);
        chk("to_nrv", q_rv.size(), 0);
        auto_m = 1'b1;
        tick();
        chk("to_err_pulse", err, 0);
        chk("to_gap_gnt", gnt, 0);
        tick();
        chk("to_idle_gnt", gnt, 0);
        tick();
        chk("to_next_gnt", gnt, 4'b0100);
        req = 4'b0000;
        wait_done("to_next_done");
        wait_idle("to_idle");
`else
        chk("err_tied", err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
